// File: rtl/midi_uart_receiver_pkg.sv
// Shared MIDI receive definitions: clock/baud defaults, FSM encoding, status-byte constants, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package midi_uart_receiver_pkg;

    // Board defaults; the top-level parameters may override them.
    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int BAUD_DEFAULT   = 31_250;

    // The bit counter is sized for 50 MHz / 31250 baud (1600 ticks) and is never allowed to wrap.
    localparam int CNT_W = 11;

    // Status bytes shared with the downstream message processor.
    localparam logic [7:0] MIDI_NOTE_OFF   = 8'h80;
    localparam logic [7:0] MIDI_NOTE_ON    = 8'h90;
    localparam logic [7:0] MIDI_CONTROLLER = 8'hB0;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    // 2-of-3 vote used to reject single-cycle spikes at the sample point.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/midi_uart_receiver_rx_sync.sv
// Brings MIDI_RX into the clock domain (2 flops) and produces the bit-sampling value.
// Latency: rx_sync 2 clk after the line; rx_sample equals rx_sync, or the majority-voted value under MIDI_RX_MAJORITY_EN.
// Backpressure: none; free-running.
module midi_uart_receiver_rx_sync
    import midi_uart_receiver_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx_line,
    output logic rx_sync,
    output logic rx_sample
);

    logic rx_meta;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_sync <= rx_meta;
        end
    end

`ifdef MIDI_RX_MAJORITY_EN
    // rx_hist[0] is rx_sync one cycle ago, rx_hist[1] two cycles ago. The FSM takes its
    // decision one cycle after the nominal sample point, so the vote is centred on it.
    logic [1:0] rx_hist;

    // Short history of the synchronised line for the 3-tap vote.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_sync};
        end
    end

    assign rx_sample = maj3(rx_hist[1], rx_hist[0], rx_sync);
`else
    assign rx_sample = rx_sync;
`endif

endmodule

// File: rtl/midi_uart_receiver.sv
// MIDI 8N1 receiver: recovers bytes from MIDI_RX, 1-cycle strobe per good byte or framing error.
// Latency: 3 + HALF_TICKS + 9*BIT_TICKS clk from MIDI_RX falling to strobe (+1 with MIDI_RX_MAJORITY_EN).
// Backpressure: none; the consumer must accept every strobe. Optional feature macro: MIDI_RX_MAJORITY_EN.
module midi_uart_receiver
    import midi_uart_receiver_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int BAUD   = BAUD_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       MIDI_RX,
    output logic       isByteAvailable,
    output logic [7:0] byteValue,
    output logic       framingError
);

    localparam int BIT_TICKS  = CLK_HZ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;

`ifdef MIDI_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so every decision slips by one clock.
    // Only the start-bit interval is stretched; later bit intervals stay BIT_TICKS long.
    localparam int SAMPLE_DELAY = 1;
`else
    localparam int SAMPLE_DELAY = 0;
`endif

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_TICKS - 1 + SAMPLE_DELAY);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TICKS - 1);

    logic            rx_s;
    logic            rx_sample;
    rx_state_t       state;
    rx_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            cnt_last;
    logic            shift_en;
    logic            good_byte;
    logic            frame_err;

    midi_uart_receiver_rx_sync u_rx_sync (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .rx_line   (MIDI_RX),
        .rx_sync   (rx_s),
        .rx_sample (rx_sample)
    );

    // Terminal count: half a bit in START (mid start bit), a full bit elsewhere.
    assign cnt_last = (state == ST_START) ? (cnt == START_LAST) : (cnt == BIT_LAST);

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_s) state_nxt = ST_START;
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_last) state_nxt = rx_sample ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (cnt_last && (bit_idx == 3'd7)) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (cnt_last) state_nxt = rx_sample ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                // A held-low line stays here so it reports only one framing error.
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state action decode feeding the datapath and output registers.
    always_comb begin
        shift_en  = 1'b0;
        good_byte = 1'b0;
        frame_err = 1'b0;
        case (state)
            ST_DATA: shift_en  = cnt_last;
            ST_STOP: begin
                good_byte = cnt_last & rx_sample;
                frame_err = cnt_last & ~rx_sample;
            end
            default: ;
        endcase
    end

    // Bit-period counter: runs only while framing a byte, cleared at every terminal count.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if ((state == ST_IDLE) || (state == ST_BREAK) || cnt_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Data bit index, counts the eight data bits of the current frame.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            bit_idx <= 3'd0;
        end else if (state != ST_DATA) begin
            bit_idx <= 3'd0;
        end else if (cnt_last) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Shift register, LSB arrives first so new bits enter at the top.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            shift <= 8'h00;
        end else if (shift_en) begin
            shift <= {rx_sample, shift[7:1]};
        end
    end

    // Registered outputs: single-cycle strobes, byte value held until the next good byte.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            isByteAvailable <= 1'b0;
            framingError    <= 1'b0;
            byteValue       <= 8'h00;
        end else begin
            isByteAvailable <= good_byte;
            framingError    <= frame_err;
            if (good_byte) byteValue <= shift;
        end
    end

endmodule

// File: tb/tb_midi_uart_receiver.sv
// Bench for midi_uart_receiver at a reduced clock (32 clk per bit) so the run stays short.
// Frames are generated from a bit-level description of the line; expected events come from the frame contents.
// Build with or without MIDI_RX_MAJORITY_EN; expectations follow the same macro.
module tb_midi_uart_receiver;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 31_250;
    localparam int B      = CLK_HZ / BAUD;
    localparam int H      = B / 2;
`ifdef MIDI_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Clock edges from driving the start bit to the edge that registers the strobe.
    localparam int LAT = 3 + H + 9 * B + MAJ;

    typedef struct {
        int          kind;   // 1 = good byte, 2 = framing error
        logic [7:0]  val;
        longint      cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       byte_vld;
    logic [7:0] byte_dat;
    logic       frame_err;

    longint     cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    ev_t        exp_q[$];
    ev_t        obs_q[$];
    ev_t        mon_ev;
    logic       prev_strobe = 1'b0;
    logic [7:0] last_good = 8'h00;

    midi_uart_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .CLOCK_50        (clk),
        .RESET_N         (rst_n),
        .MIDI_RX         (rx),
        .isByteAvailable (byte_vld),
        .byteValue       (byte_dat),
        .framingError    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe strobes away from the active edge and log them.
    always @(negedge clk) begin
        if (byte_vld || frame_err) begin
            chk("strobe_exclusive", {31'b0, byte_vld & frame_err}, 32'd0);
            chk("strobe_single_cycle", {31'b0, prev_strobe}, 32'd0);
            mon_ev.kind = byte_vld ? 1 : 2;
            mon_ev.val  = byte_dat;
            mon_ev.cyc  = cyc;
            obs_q.push_back(mon_ev);
        end
        prev_strobe = byte_vld || frame_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level c clocks into a frame: start bit, 8 data bits LSB first, stop bit.
    function automatic logic line_val(input logic [7:0] d, input logic stop, input int c);
        int b;
        b = c / B;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return stop;
    endfunction

    // Reference model: what the receiver should report for one frame.
    // A spike exactly at a data bit's mid-point corrupts that bit only for a single-sample receiver.
    task automatic expect_frame(input logic [7:0] d, input logic stop, input int spike_c, input longint t0);
        ev_t        e;
        logic [7:0] v;
        v = d;
        if (MAJ == 0 && spike_c >= 0) begin
            for (int i = 0; i < 8; i++) begin
                if (spike_c == H + (i + 1) * B) v[i] = 1'b1;
            end
        end
        e.cyc = t0 + LAT;
        if (stop) begin
            e.kind = 1;
            e.val  = v;
            last_good = v;
        end else begin
            e.kind = 2;
            e.val  = last_good;
        end
        exp_q.push_back(e);
    endtask

    // Drive one full frame; caller is positioned just after a rising edge.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_c);
        longint t0;
        t0 = cyc;
        for (int c = 0; c < 10 * B; c++) begin
            if (c > 0) tick();
            rx = (c == spike_c) ? 1'b1 : line_val(d, stop, c);
        end
        tick();
        expect_frame(d, stop, spike_c, t0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Match observed events against the model, in order, with +-2 clk latency tolerance.
    task automatic drain(input string tag);
        ev_t e;
        ev_t o;
        longint d;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, "_missing_event"}, 32'd0, 32'd1);
            end else begin
                o = obs_q.pop_front();
                d = o.cyc - e.cyc;
                chk({tag, "_kind"}, o.kind, e.kind);
                chk({tag, "_value"}, {24'b0, o.val}, {24'b0, e.val});
                chk({tag, "_latency_ok"}, {31'b0, (d >= -2 && d <= 2)}, 32'd1);
            end
        end
        chk({tag, "_extra_events"}, obs_q.size(), 32'd0);
        obs_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         gap;

        // Reset state.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("reset_byte_vld", {31'b0, byte_vld}, 32'd0);
        chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
        chk("reset_byte_dat", {24'b0, byte_dat}, 32'd0);
        tick();
        rst_n = 1'b1;
        idle(B);

        // Single note-on status byte.
        send_frame(8'h90, 1'b1, -1);
        idle(B);
        drain("single_0x90");
        chk("single_hold", {24'b0, byte_dat}, 32'h90);

        // Back-to-back frames with no idle time between them.
        send_frame(8'h90, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        send_frame(8'h64, 1'b1, -1);
        idle(B);
        drain("b2b");

        // Short low glitch on an idle line must not start a frame.
        rx = 1'b0;
        repeat (8) tick();
        idle(2 * B);
        drain("glitch");

        // Stop bit low, line then held low: one framing error, byte value unchanged.
        send_frame(8'h55, 1'b0, -1);
        rx = 1'b0;
        repeat (50000) tick();
        drain("break");
        chk("break_byte_hold", {24'b0, byte_dat}, {24'b0, last_good});
        idle(2 * B);
        send_frame(8'h80, 1'b1, -1);
        idle(B);
        drain("after_break");

        // Reset asserted during data bit 3 of 0xB0 aborts silently.
        for (int c = 0; c < 4 * B + B / 4; c++) begin
            if (c > 0) tick();
            rx = line_val(8'hB0, 1'b1, c);
        end
        tick();
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("midreset_byte_dat", {24'b0, byte_dat}, 32'd0);
        chk("midreset_byte_vld", {31'b0, byte_vld}, 32'd0);
        tick();
        rst_n = 1'b1;
        last_good = 8'h00;
        idle(2 * B);
        drain("midreset");
        send_frame(8'h01, 1'b1, -1);
        idle(B);
        drain("after_reset");

        // One-clock high spike at the bit-4 sample point of 0x00.
        send_frame(8'h00, 1'b1, H + 5 * B);
        idle(B);
        drain("spike");
        chk("spike_value", {24'b0, byte_dat}, (MAJ != 0) ? 32'h00 : 32'h10);

        // Random bytes with random (possibly zero) idle gaps.
        for (int k = 0; k < 12; k++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = (k % 3 == 0) ? 0 : int'($urandom_range(1, 2 * B));
            if (gap > 0) idle(gap);
            send_frame(rb, 1'b1, -1);
        end
        idle(B);
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
